// File: rtl/gate_test_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gate_test_pkg
//  Description : Shared types and truth-table constants for the gate tester.
//  Revision    : 1.0 - initial release
// ============================================================================
package gate_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int VEC_COUNT = 4;

    localparam logic [VEC_COUNT-1:0] TT_NOR  = 4'b0001;
    localparam logic [VEC_COUNT-1:0] TT_NAND = 4'b0111;
    localparam logic [VEC_COUNT-1:0] TT_AND  = 4'b1000;
    localparam logic [VEC_COUNT-1:0] TT_OR   = 4'b1110;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [1:0] lowest_set(input logic [VEC_COUNT-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = VEC_COUNT - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : settle_timer
//  Description : Settle-time counter with clear, increment and terminal flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam logic [7:0] c_TC = 8'(SETTLE_CYCLES - 1);

    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else if (clr_i) begin
            cnt_q <= 8'd0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign tc_o = (cnt_q == c_TC);

endmodule
`default_nettype wire

// File: rtl/gate_tt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : gate_tt_sequencer
//  Description : Sweeps a 2-input gate through all input vectors and compares
//                the measured truth table against a latched expectation.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_tt_sequencer
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [3:0] expected_i,
    output logic       dut_in1_o,
    output logic       dut_in2_o,
    input  logic       dut_out_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [3:0] table_o,
    output logic [1:0] first_fail_o
);

    localparam logic [1:0] c_LAST_VEC = 2'(VEC_COUNT - 1);

    state_t     state_q;
    logic [1:0] vec_q;
    logic [3:0] exp_q;
    logic [3:0] table_q;
    logic       pass_q;
    logic [1:0] first_fail_q;
    logic       busy_q;
    logic       done_q;

    logic       w_accept;
    logic       w_tc;
    logic       w_sample_bit;
    logic [3:0] w_table_d;
    logic [3:0] w_mismatch;

    assign w_accept = (state_q == ST_IDLE) && start_i;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (w_accept || (state_q == ST_SAMPLE)),
        .inc_i (state_q == ST_SETTLE),
        .tc_o  (w_tc)
    );

    // A non-0/1 level matches neither case item and is forced to disagree
    // with the expected bit so that vector reports as a mismatch.
    always_comb begin
        case (dut_out_i)
            1'b0:    w_sample_bit = 1'b0;
            1'b1:    w_sample_bit = 1'b1;
            default: w_sample_bit = ~exp_q[vec_q];
        endcase
    end

    always_comb begin
        w_table_d        = table_q;
        w_table_d[vec_q] = w_sample_bit;
    end

    assign w_mismatch = w_table_d ^ exp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vec_q        <= 2'd0;
            exp_q        <= 4'd0;
            table_q      <= 4'd0;
            pass_q       <= 1'b0;
            first_fail_q <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        exp_q        <= expected_i;
                        vec_q        <= 2'd0;
                        table_q      <= 4'd0;
                        pass_q       <= 1'b0;
                        first_fail_q <= 2'd0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_tc) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    table_q <= w_table_d;
                    if (vec_q == c_LAST_VEC) begin
                        pass_q       <= (w_mismatch == 4'd0);
                        first_fail_q <= lowest_set(w_mismatch);
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        vec_q   <= vec_q + 2'd1;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dut_in1_o    = vec_q[0];
    assign dut_in2_o    = vec_q[1];
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign table_o      = table_q;
    assign first_fail_o = first_fail_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_tt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_tt_sequencer
//  Description : Self-checking bench with a behavioural sweep model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_tt_sequencer;
    import gate_test_pkg::*;

    localparam int S = 2;
    localparam int P = S + 1;
    localparam int SWEEP = 4 * P;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] expected = 4'd0;
    logic       dut_in1, dut_in2, dut_out;
    logic       busy, done, pass;
    logic [3:0] tbl;
    logic [1:0] ff;
    int         gut_mode = 0;

    logic       s1_start = 1'b0;
    logic       s1_out = 1'b0;
    logic       s1_in1, s1_in2, s1_busy, s1_done, s1_pass;
    logic [3:0] s1_tbl;
    logic [1:0] s1_ff;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // Gate under test: 0 NOR, 1 NAND, 2 stuck-at-0, 3 AND, 4 OR
    function automatic logic gut(input int mode, input logic a, input logic b);
        case (mode)
            0:       return ~(a | b);
            1:       return ~(a & b);
            2:       return 1'b0;
            3:       return a & b;
            default: return a | b;
        endcase
    endfunction

    assign dut_out = gut(gut_mode, dut_in1, dut_in2);

    gate_tt_sequencer #(.SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .rst(rst), .start_i(start), .expected_i(expected),
        .dut_in1_o(dut_in1), .dut_in2_o(dut_in2), .dut_out_i(dut_out),
        .busy_o(busy), .done_o(done), .pass_o(pass),
        .table_o(tbl), .first_fail_o(ff)
    );

    gate_tt_sequencer #(.SETTLE_CYCLES(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .start_i(s1_start), .expected_i(TT_NOR),
        .dut_in1_o(s1_in1), .dut_in2_o(s1_in2), .dut_out_i(s1_out),
        .busy_o(s1_busy), .done_o(s1_done), .pass_o(s1_pass),
        .table_o(s1_tbl), .first_fail_o(s1_ff)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] first_diff(input logic [3:0] a, input logic [3:0] b);
        for (int i = 0; i < 4; i++) begin
            if (a[i] != b[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    // Model: m_k = cycles since accept (1..SWEEP busy, SWEEP+1 done), -1 idle.
    int         m_k = -1;
    logic [3:0] m_exp = 4'd0;
    logic [3:0] m_meas = 4'd0;
    logic       m_pass = 1'b0;
    logic [1:0] m_ff = 2'd0;
    logic [1:0] m_vec = 2'd0;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin : b_model
        int v;
        cyc++;
        if (rst) begin
            m_k = -1; m_meas = 4'd0; m_pass = 1'b0; m_ff = 2'd0; m_vec = 2'd0;
            m_valid = 1'b1;
        end else if (m_k < 0) begin
            if (start) begin
                m_k = 1; m_exp = expected; m_meas = 4'd0;
                m_pass = 1'b0; m_ff = 2'd0; m_vec = 2'd0;
            end
        end else if (m_k <= SWEEP) begin
            v = (m_k - 1) / P;
            if ((m_k - 1) % P == P - 1) begin
                m_meas[v] = gut(gut_mode, v[0], v[1]);
            end
            if (m_k == SWEEP) begin
                m_pass = (m_meas == m_exp);
                m_ff   = first_diff(m_meas, m_exp);
            end
            m_k++;
            if (m_k <= SWEEP) m_vec = 2'((m_k - 1) / P);
        end else begin
            m_k = -1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", busy, (m_k >= 1) && (m_k <= SWEEP));
            check("done", done, m_k == SWEEP + 1);
            check("dut_in", {dut_in2, dut_in1}, m_vec);
            check("table", tbl, m_meas);
            check("pass", pass, m_pass);
            check("first_fail", ff, m_ff);
        end
    end

    // Starts one sweep from an IDLE cycle; returns start-to-done cycles and
    // the sequence of input vectors seen while busy.
    task automatic run_sweep(output int dt, output logic [7:0] seq);
        int         t0;
        logic [1:0] last;
        bit         seen;
        seen = 1'b0; last = 2'd0; seq = 8'd0; dt = -1;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (busy && (!seen || {dut_in2, dut_in1} != last)) begin
                seq  = {seq[5:0], dut_in2, dut_in1};
                last = {dut_in2, dut_in1};
                seen = 1'b1;
            end
            if (done) begin
                dt = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        if (dt < 0) check("done_timeout", 0, 1);
    endtask

    initial begin : b_stim
        int         dt, t0, r, ndone;
        int         tdone[3];
        logic       pdone[3];
        logic [7:0] seq;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_table", tbl, 0);
        check("rst_inputs", {dut_in2, dut_in1}, 0);
        rst = 1'b0;

        // NOR gate against its own table
        gut_mode = 0; expected = TT_NOR;
        run_sweep(dt, seq);
        check("nor_latency", dt, 13);
        check("nor_seq", seq, 8'h1B);
        check("nor_table", tbl, 4'b0001);
        check("nor_pass", pass, 1);
        check("nor_ff", ff, 0);

        // NOR gate against AND table
        expected = TT_AND;
        run_sweep(dt, seq);
        check("and_table", tbl, 4'b0001);
        check("and_pass", pass, 0);
        check("and_ff", ff, 0);

        // Stuck-at-0 output against NOR table
        gut_mode = 2; expected = TT_NOR;
        run_sweep(dt, seq);
        check("sa0_table", tbl, 4'b0000);
        check("sa0_pass", pass, 0);
        check("sa0_ff", ff, 0);

        // NAND against OR table: mismatch first at vector 0
        gut_mode = 1; expected = TT_OR;
        run_sweep(dt, seq);
        check("nand_table", tbl, TT_NAND);
        check("nand_ff", ff, 0);

        // Start pulses mid-sweep are ignored
        gut_mode = 0; expected = TT_NOR; ndone = 0;
        @(negedge clk);
        start = 1'b1; t0 = cyc;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            r = cyc - t0;
            start = (r == 3) || (r == 12);
            if (done) ndone++;
        end
        start = 1'b0;
        check("ignore_start_dones", ndone, 1);

        // Reset during vector 2
        @(negedge clk);
        start = 1'b1; t0 = cyc; ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start = 1'b0;
            r = cyc - t0;
            rst = (r == 8);
            if (r == 9) begin
                check("midrst_busy", busy, 0);
                check("midrst_vals", {done, pass, tbl, ff, dut_in2, dut_in1}, 0);
            end
            if (done) ndone++;
        end
        check("midrst_nodone", ndone, 0);
        run_sweep(dt, seq);
        check("after_rst_latency", dt, 13);
        check("after_rst_pass", pass, 1);

        // Start held for three sweeps with expected toggling mid-sweep
        @(negedge clk);
        start = 1'b1; expected = TT_NOR; t0 = cyc; ndone = 0;
        for (int i = 0; i < 100 && ndone < 3; i++) begin
            @(negedge clk);
            r = cyc - t0;
            if (r == 7)  expected = TT_AND;
            if (r == 21) expected = TT_NOR;
            if (done) begin
                tdone[ndone] = r;
                pdone[ndone] = pass;
                ndone++;
            end
        end
        start = 1'b0;
        check("held_dones", ndone, 3);
        if (ndone == 3) begin
            check("held_gap1", tdone[1] - tdone[0], 14);
            check("held_gap2", tdone[2] - tdone[1], 14);
            check("held_pass", {pdone[0], pdone[1], pdone[2]}, 3'b101);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 79) == 0);
            start    = ($urandom_range(0, 2) != 0);
            expected = 4'($urandom);
            if ($urandom_range(0, 9) == 0) gut_mode = int'($urandom_range(0, 4));
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (20) @(negedge clk);

        // Short settle: stuck-at-0 output, NOR expectation
        s1_start = 1'b1; t0 = cyc; dt = -1;
        @(negedge clk);
        s1_start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (s1_done) begin
                dt = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        check("s1_latency", dt, 9);
        check("s1_table", s1_tbl, 4'b0000);
        check("s1_pass", s1_pass, 0);
        check("s1_ff", s1_ff, 0);
        check("s1_busy", s1_busy, 0);
        check("s1_inputs", {s1_in2, s1_in1}, 2'b11);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/gate_tt_sequencer.md
GATE_TT_SEQUENCER -- requirements
Module: gate_tt_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles the gate-under-test (GUT) inputs are held before each output sample; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to run one truth-table sweep; sampled only in IDLE.
REQ-005 expected  input  4  expected truth table, bit i = GUT output for vector i; latched when start is accepted.
REQ-006 dut_in1  output  1  drives GUT in1; equals vec[0].
REQ-007 dut_in2  output  1  drives GUT in2; equals vec[1].
REQ-008 dut_out  input  1  GUT output (e.g. a 2-input CMOS NOR cell).
REQ-009 busy  output  1  high from the cycle after start is accepted through the last SAMPLE cycle.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 pass  output  1  result of last sweep: measured table equals latched expected; held until next accepted start.
REQ-012 table  output  4  measured truth table of last sweep, bit i = dut_out sampled for vector i.
REQ-013 first_fail  output  2  lowest vector index with mismatch; 0 when pass=1.

Function
REQ-014 States: IDLE, SETTLE, SAMPLE, DONE.
REQ-015 IDLE: start=1 -> latch expected, vec<=0, cnt<=0, clear table, next SETTLE; start=0 -> stay.
REQ-016 SETTLE: cnt increments each cycle; at cnt==SETTLE_CYCLES-1 -> SAMPLE, else stay.
REQ-017 SAMPLE: table[vec]<=dut_out; vec==3 -> DONE; else vec<=vec+1, cnt<=0, -> SETTLE.
REQ-018 DONE: done=1 for exactly this cycle; pass, first_fail, table valid this cycle and thereafter; -> IDLE.
REQ-019 Each vector occupies SETTLE_CYCLES+1 cycles; done rises 4*(SETTLE_CYCLES+1)+1 cycles after the start-accept edge.
REQ-020 dut_in1/dut_in2 change only on the edge entering SETTLE, never during SETTLE or SAMPLE of a vector.
REQ-021 start while busy or in DONE is ignored; no queuing.
REQ-022 start held high continuously launches a new sweep on each return to IDLE (one IDLE cycle between sweeps).
REQ-023 A dut_out value that is not 0/1 (X/Z, simulation only) is recorded as a mismatch for that vector.
REQ-024 expected changes after acceptance have no effect on the running sweep.

Reset
REQ-025 rst=1 at any clock edge, including mid-sweep: state<=IDLE, vec<=0, cnt<=0, dut_in1=dut_in2=0, busy=0, done=0, pass=0, table=0, first_fail=0.
REQ-026 rst has priority over start in the same cycle; a sweep interrupted by reset produces no done pulse.

Structure
REQ-027 Package gate_test_pkg holds: state enum, VEC_COUNT=4, expected-table constants TT_NOR=4'b0001, TT_NAND=4'b0111, TT_AND=4'b1000, TT_OR=4'b1110.
REQ-028 One sub-module, settle_timer (cnt load/increment, terminal-count flag); everything else in gate_tt_sequencer.

Verification
REQ-029 GUT=2-input CMOS NOR, expected=TT_NOR, SETTLE_CYCLES=2 -> dut_in sequence 00,01,10,11; done at cycle 13 after start; table=0001, pass=1, first_fail=0.
REQ-030 GUT=NOR, expected=TT_AND -> table=0001, pass=0, first_fail=0.
REQ-031 GUT output stuck-at-0, expected=TT_NOR -> table=0000, pass=0, first_fail=0; SETTLE_CYCLES=1 -> done at cycle 9.
REQ-032 Pulse start again at cycles 3 and 12 of a running sweep -> ignored; exactly one done pulse; inputs unchanged mid-vector.
REQ-033 rst asserted one cycle during vector 2 -> all outputs at reset values next cycle, no done; subsequent start runs a full correct sweep.
REQ-034 start held high 3 sweeps, expected toggled mid-sweep -> 3 done pulses 14 cycles apart (SETTLE_CYCLES=2), each pass per its latched expected.
